vector_floating_point_merge_sequencer: RTL and testbench
========================================================

VECTOR_FLOATING_POINT_MERGE_SEQUENCER -- requirements
Module: vector_floating_point_merge_sequencer

Interface
REQ-001 SHALL have parameters: VLEN, 128, vector register width in bits; BEAT_WIDTH, 64, bits processed per cycle (VLEN multiple of BEAT_WIDTH, BEAT_WIDTH >= 64).
REQ-002 SHALL have ports, one clock, reset asynchronous active-high: clock input 1 system clock; reset input 1 async active-high reset.
REQ-003 SHALL have ports: in_valid input 1, request valid; in_ready output 1, request accepted when high with in_valid.
REQ-004 SHALL have ports: sew input 2, vsew encoding (00=8 illegal, 01=16, 10=32, 11=64); vm input 1, 1=vfmv.v.f, 0=vfmerge.vfm; vta input 1, tail agnostic.
REQ-005 SHALL have ports: vl input $clog2(VLEN/16)+1, vector length; vstart input $clog2(VLEN/16), first active element.
REQ-006 SHALL have ports: rs1 input 64, scalar FP operand; vs2 input VLEN; v0 input VLEN mask; vd_old input VLEN, destination prior contents.
REQ-007 SHALL have ports: out_valid output 1, result valid; out_ready input 1, consumer accepts; vd output VLEN, result; illegal output 1, sew=00 flag, valid with out_valid.

Function
REQ-008 SHALL have FSM states IDLE, BUSY, DONE; in_ready=1 only in IDLE; out_valid=1 only in DONE.
REQ-009 SHALL, on in_valid&&in_ready, register all operands, clamp vl to VLMAX=VLEN/SEW, clear beat counter, go BUSY.
REQ-010 SHALL process one BEAT_WIDTH slice per cycle in BUSY; after beat VLEN/BEAT_WIDTH-1 go DONE; accept-to-out_valid latency = VLEN/BEAT_WIDTH+1 cycles.
REQ-011 SHALL, for element i with vstart <= i < vl: vd[i] = (vm || v0[i]) ? scalar : vs2[i].
REQ-012 SHALL, for i < vstart, write vd_old[i] (prestart undisturbed).
REQ-013 SHALL, for i >= vl, write vd_old[i] when vta=0, all-ones when vta=1.
REQ-014 SHALL derive scalar for SEW<64 from rs1 low SEW bits only if rs1[63:SEW] all ones (NaN-boxed); otherwise canonical NaN (16'h7E00, 32'h7FC0_0000).
REQ-015 SHALL use rs1 unmodified at SEW=64.
REQ-016 SHALL, when vstart >= vl (incl. vl=0), return vd = vd_old in every element regardless of vta, still taking full latency.
REQ-017 SHALL, for sew=00, skip BUSY, go directly to DONE next cycle with illegal=1, vd = vd_old.
REQ-018 SHALL hold vd, illegal, out_valid stable in DONE until out_ready; on out_valid&&out_ready return to IDLE.
REQ-019 SHALL ignore in_valid outside IDLE; operand inputs changing during BUSY SHALL NOT affect the result.
REQ-020 SHALL NOT raise FP exception flags (merge is a move).

Reset
REQ-021 SHALL, on reset asserted at any time including mid-BUSY/DONE, enter IDLE asynchronously: in_ready=1, out_valid=0, illegal=0, vd=0, beat counter=0, operand registers=0.
REQ-022 SHALL resume accepting on first rising clock edge after reset deasserts.

Structure
REQ-023 SHALL take VLEN from dragonfang_pkg; SEW encoding enum and canonical NaN constants in dragonfang_floating_point_pkg; FSM state enum local.
REQ-024 SHALL instantiate one combinational sub-module vector_floating_point_merge_lane computing one BEAT_WIDTH slice (inputs: beat index, sew, vm, vta, vl, vstart, scalar, slices of vs2/v0/vd_old).

Verification
REQ-025 SHALL test: VLEN=128, SEW=64, vm=0, vl=2, vstart=0, v0=...01, rs1=64'h4000_0000_0000_0000, vs2={A,B} -> vd={A,64'h4000_0000_0000_0000}, out_valid 3 cycles after accept.
REQ-026 SHALL test: SEW=32, vm=1, vl=3, vta=1, rs1=64'hFFFF_FFFF_3F80_0000 -> elements0-2=32'h3F80_0000, element3=32'hFFFF_FFFF.
REQ-027 SHALL test: SEW=32, vm=1, vl=4, rs1=64'h0000_0000_3F80_0000 (not NaN-boxed) -> all elements 32'h7FC0_0000.
REQ-028 SHALL test: SEW=16, vstart=2, vl=6, vta=0, vm=1, rs1 boxed 16'h3C00 -> elements0-1 and 6-7 equal vd_old, elements2-5=16'h3C00.
REQ-029 SHALL test: out_ready held low 5 cycles -> vd stable, in_ready=0; then reset mid-BUSY of next op -> out_valid=0, vd=0, in_ready=1 immediately.
REQ-030 SHALL test: sew=00 -> out_valid one cycle after accept, illegal=1, vd=vd_old; vl=0 -> vd=vd_old after full latency.

Source files
------------

// File: rtl/dragonfang_floating_point_pkg.sv
// Floating-point element-width encodings, canonical NaNs and the NaN-box unpack helper.
package dragonfang_floating_point_pkg;

  typedef enum logic [1:0] {
    SEW_8  = 2'b00,
    SEW_16 = 2'b01,
    SEW_32 = 2'b10,
    SEW_64 = 2'b11
  } sew_e;

  localparam logic [15:0] CANON_NAN_H = 16'h7E00;
  localparam logic [31:0] CANON_NAN_S = 32'h7FC0_0000;

  // Narrow scalars must be NaN-boxed in the 64-bit register; anything else reads as canonical NaN.
  function automatic logic [63:0] unbox_scalar(input sew_e sew, input logic [63:0] rs1);
    logic [63:0] s;
    s = rs1;
    case (sew)
      SEW_16:  s = (&rs1[63:16]) ? {48'h0, rs1[15:0]} : {48'h0, CANON_NAN_H};
      SEW_32:  s = (&rs1[63:32]) ? {32'h0, rs1[31:0]} : {32'h0, CANON_NAN_S};
      default: s = rs1;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/dragonfang_pkg.sv
// Machine-wide vector configuration shared by the dragonfang vector units.
package dragonfang_pkg;

  localparam int VLEN = 128;

endpackage

// File: rtl/vector_floating_point_merge_lane.sv
// Combinational merge of one beat-wide slice; works in 16-bit chunks so every legal SEW
// maps onto whole chunks.
module vector_floating_point_merge_lane #(
  parameter int VLEN       = 128,
  parameter int BEAT_WIDTH = 64,
  localparam int NBEATS = VLEN / BEAT_WIDTH,
  localparam int BI_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1,
  localparam int CHUNKS = BEAT_WIDTH / 16,
  localparam int CW     = $clog2(CHUNKS),
  localparam int EW     = $clog2(VLEN / 16) + 1
) (
  input  logic [BI_W-1:0]       beat,
  input  logic [1:0]            sew,
  input  logic                  vm,
  input  logic                  vta,
  input  logic [EW-1:0]         vl,
  input  logic [EW-2:0]         vstart,
  input  logic [63:0]           scalar,
  input  logic [BEAT_WIDTH-1:0] vs2,
  input  logic [CHUNKS-1:0]     mask,
  input  logic [BEAT_WIDTH-1:0] vd_old,
  output logic [BEAT_WIDTH-1:0] vd
);

  logic [1:0] shamt;
  logic       empty;

  always_comb begin
    shamt = (sew == 2'b00) ? 2'd0 : sew - 2'd1;
    // vstart at or past vl leaves the whole register untouched, tail included.
    empty = ({1'b0, vstart} >= vl);
  end

  for (genvar gi = 0; gi < CHUNKS; gi++) begin : g_chunk
    logic [EW-1:0] gidx;
    logic [EW-1:0] eidx;
    logic [CW-1:0] lidx;
    logic [1:0]    sub;
    logic [15:0]   sc;
    logic [15:0]   res;

    always_comb begin
      gidx = EW'(beat) * EW'(CHUNKS) + EW'(gi);
      eidx = gidx >> shamt;
      lidx = CW'(gi) >> shamt;
      sub  = 2'(gi) & ((2'd1 << shamt) - 2'd1);
      sc   = scalar[16*sub +: 16];
      res  = vd_old[16*gi +: 16];
      if (!empty && (eidx >= {1'b0, vstart})) begin
        if (eidx >= vl) begin
          if (vta) res = '1;
        end else begin
          res = (vm || mask[lidx]) ? sc : vs2[16*gi +: 16];
        end
      end
    end

    assign vd[16*gi +: 16] = res;
  end

endmodule

// File: rtl/vector_floating_point_merge_sequencer.sv
// vfmerge.vfm / vfmv.v.f sequencer: captures operands, merges one beat per cycle, then
// holds the result until the consumer takes it.
module vector_floating_point_merge_sequencer
  import dragonfang_floating_point_pkg::*;
#(
  parameter int VLEN       = dragonfang_pkg::VLEN,
  parameter int BEAT_WIDTH = 64
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [1:0]                  sew,
  input  logic                        vm,
  input  logic                        vta,
  input  logic [$clog2(VLEN/16):0]    vl,
  input  logic [$clog2(VLEN/16)-1:0]  vstart,
  input  logic [63:0]                 rs1,
  input  logic [VLEN-1:0]             vs2,
  input  logic [VLEN-1:0]             v0,
  input  logic [VLEN-1:0]             vd_old,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [VLEN-1:0]             vd,
  output logic                        illegal
);

  localparam int NBEATS = VLEN / BEAT_WIDTH;
  localparam int BI_W   = (NBEATS > 1) ? $clog2(NBEATS) : 1;
  localparam int CHUNKS = BEAT_WIDTH / 16;
  localparam int VL_W   = $clog2(VLEN / 16) + 1;

  typedef enum logic [1:0] {IDLE, BUSY, DONE} state_e;

  state_e             state_reg, state_next;
  logic [BI_W-1:0]    beat_reg;
  sew_e               sew_reg;
  logic               vm_reg, vta_reg, illegal_reg;
  logic [VL_W-1:0]    vl_reg;
  logic [VL_W-2:0]    vstart_reg;
  logic [63:0]        scalar_reg;
  logic [VLEN-1:0]    vs2_reg, v0_reg, vd_old_reg, vd_reg;

  logic [1:0]            shamt_in, shamt_reg;
  logic [VL_W-1:0]       vlmax_in;
  logic                  last_beat;
  int                    beat_base;
  int                    mask_shift;
  logic [BEAT_WIDTH-1:0] vs2_slice, vd_old_slice, lane_vd;
  logic [CHUNKS-1:0]     mask_slice;

  always_comb begin
    shamt_in  = (sew == 2'b00) ? 2'd0 : sew - 2'd1;
    shamt_reg = (sew_reg == SEW_8) ? 2'd0 : 2'(sew_reg) - 2'd1;
    vlmax_in  = VL_W'(VLEN / 16) >> shamt_in;
    last_beat = (beat_reg == BI_W'(NBEATS - 1));
    beat_base = int'(beat_reg) * BEAT_WIDTH;
    // Mask bits are one per element, so the slice start depends on elements per beat.
    mask_shift   = int'(beat_reg) * ((BEAT_WIDTH / 16) >> shamt_reg);
    vs2_slice    = vs2_reg[beat_base +: BEAT_WIDTH];
    vd_old_slice = vd_old_reg[beat_base +: BEAT_WIDTH];
    mask_slice   = CHUNKS'(v0_reg >> mask_shift);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_reg <= IDLE;
    else     state_reg <= state_next;
  end

  always_comb begin
    state_next = state_reg;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    case (state_reg)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = (sew_e'(sew) == SEW_8) ? DONE : BUSY;
      end
      BUSY: if (last_beat) state_next = DONE;
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      beat_reg    <= '0;
      sew_reg     <= SEW_8;
      vm_reg      <= 1'b0;
      vta_reg     <= 1'b0;
      illegal_reg <= 1'b0;
      vl_reg      <= '0;
      vstart_reg  <= '0;
      scalar_reg  <= '0;
      vs2_reg     <= '0;
      v0_reg      <= '0;
      vd_old_reg  <= '0;
      vd_reg      <= '0;
    end else begin
      case (state_reg)
        IDLE: if (in_valid) begin
          beat_reg    <= '0;
          sew_reg     <= sew_e'(sew);
          vm_reg      <= vm;
          vta_reg     <= vta;
          vl_reg      <= (vl > vlmax_in) ? vlmax_in : vl;
          vstart_reg  <= vstart;
          scalar_reg  <= unbox_scalar(sew_e'(sew), rs1);
          vs2_reg     <= vs2;
          v0_reg      <= v0;
          vd_old_reg  <= vd_old;
          illegal_reg <= (sew_e'(sew) == SEW_8);
          // An illegal SEW bypasses the beats, so the result is loaded here.
          if (sew_e'(sew) == SEW_8) vd_reg <= vd_old;
        end
        BUSY: begin
          vd_reg[beat_base +: BEAT_WIDTH] <= lane_vd;
          beat_reg <= beat_reg + BI_W'(1);
        end
        default: ;
      endcase
    end
  end

  vector_floating_point_merge_lane #(
    .VLEN       (VLEN),
    .BEAT_WIDTH (BEAT_WIDTH)
  ) u_lane (
    .beat   (beat_reg),
    .sew    (sew_reg),
    .vm     (vm_reg),
    .vta    (vta_reg),
    .vl     (vl_reg),
    .vstart (vstart_reg),
    .scalar (scalar_reg),
    .vs2    (vs2_slice),
    .mask   (mask_slice),
    .vd_old (vd_old_slice),
    .vd     (lane_vd)
  );

  assign vd      = vd_reg;
  assign illegal = illegal_reg;

endmodule

// File: tb/tb_vector_floating_point_merge_sequencer.sv
// Scoreboard bench: driver pushes expected results, a negedge monitor checks them.
module tb_vector_floating_point_merge_sequencer;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [1:0]   sew = 2'b00;
  logic         vm = 1'b0;
  logic         vta = 1'b0;
  logic [3:0]   vl = '0;
  logic [2:0]   vstart = '0;
  logic [63:0]  rs1 = '0;
  logic [127:0] vs2 = '0, v0 = '0, vd_old = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [127:0] vd;
  logic         illegal;

  vector_floating_point_merge_sequencer #(.VLEN(128), .BEAT_WIDTH(64)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
    .sew(sew), .vm(vm), .vta(vta), .vl(vl), .vstart(vstart), .rs1(rs1),
    .vs2(vs2), .v0(v0), .vd_old(vd_old), .out_valid(out_valid),
    .out_ready(out_ready), .vd(vd), .illegal(illegal)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [127:0] vd;
    logic         ill;
    int           acc;
    int           lat;
  } exp_t;

  exp_t q[$];
  int   n_checks = 0;
  int   n_fail = 0;
  int   n_txn = 0;
  logic hold_rdy = 1'b0;
  logic force_rdy = 1'b0;

  task automatic chk_v(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_i(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic timeout(input string name);
    n_checks++;
    n_fail++;
    $display("FAIL %s: bound expired at cycle %0d", name, cyc);
  endtask

  function automatic logic [127:0] rand128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Element-by-element reference of the merge rules.
  function automatic logic [127:0] model(input logic [1:0] s, input logic m, input logic t,
                                         input int l_in, input int st, input logic [63:0] r,
                                         input logic [127:0] a, input logic [127:0] msk,
                                         input logic [127:0] old);
    logic [127:0] res;
    logic [63:0]  sc, e;
    int sw, vlmax, l;
    res = old;
    if (s == 2'b00) return old;
    sw = 8 << s;
    vlmax = 128 / sw;
    l = (l_in > vlmax) ? vlmax : l_in;
    if (sw == 64) sc = r;
    else if ((r >> sw) == ((64'd1 << (64 - sw)) - 64'd1)) sc = r;
    else sc = (sw == 16) ? 64'h7E00 : 64'h7FC0_0000;
    if (st >= l) return old;
    for (int i = st; i < vlmax; i++) begin
      if (i >= l) e = t ? '1 : 64'(old >> (i * sw));
      else e = (m || msk[i]) ? sc : 64'(a >> (i * sw));
      for (int b = 0; b < sw; b++) res[i*sw + b] = e[b];
    end
    return res;
  endfunction

  task automatic issue(input logic [1:0] s, input logic m, input logic t, input logic [3:0] l,
                       input logic [2:0] st, input logic [63:0] r, input logic [127:0] a,
                       input logic [127:0] msk, input logic [127:0] old,
                       input logic use_ex, input logic [127:0] ex);
    exp_t e;
    int k;
    @(negedge clk);
    sew = s; vm = m; vta = t; vl = l; vstart = st; rs1 = r;
    vs2 = a; v0 = msk; vd_old = old; in_valid = 1'b1;
    k = 0;
    while (!in_ready && k < 300) begin
      @(negedge clk);
      k++;
    end
    if (!in_ready) begin
      timeout("accept");
      in_valid = 1'b0;
      return;
    end
    e.vd  = use_ex ? ex : model(s, m, t, int'(l), int'(st), r, a, msk, old);
    e.ill = (s == 2'b00);
    e.acc = cyc;
    e.lat = (s == 2'b00) ? 1 : 3;
    q.push_back(e);
    n_txn++;
    $display("txn %0d: sew=%0d vm=%0d vta=%0d vl=%0d vstart=%0d rs1=%h exp=%h",
             n_txn, s, m, t, l, st, r, e.vd);
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    // Operands change after acceptance; the result must not follow them.
    sew = 2'($urandom); vm = 1'($urandom); vta = 1'($urandom);
    vl = 4'($urandom); vstart = 3'($urandom); rs1 = {$urandom, $urandom};
    vs2 = rand128(); v0 = rand128(); vd_old = rand128();
  endtask

  task automatic drain(input int bound);
    int k;
    k = 0;
    while (q.size() != 0 && k < bound) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) timeout("drain");
  endtask

  initial begin
    forever begin
      @(posedge clk);
      #1;
      out_ready = hold_rdy ? 1'b0 : (force_rdy ? 1'b1 : ($urandom_range(0, 3) != 0));
    end
  end

  logic         seen = 1'b0;
  logic [127:0] first_vd;
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        seen = 1'b0;
      end else if (out_valid) begin
        if (q.size() == 0) begin
          timeout("unexpected_out_valid");
        end else begin
          if (!seen) begin
            chk_i("latency", cyc - q[0].acc, q[0].lat);
            first_vd = vd;
            seen = 1'b1;
          end else begin
            chk_v("hold_vd", vd, first_vd);
          end
          chk_i("in_ready_in_done", int'(in_ready), 0);
          if (out_ready) begin
            chk_v("vd", vd, q[0].vd);
            chk_i("illegal", int'(illegal), int'(q[0].ill));
            void'(q.pop_front());
            seen = 1'b0;
          end
        end
      end else if (seen) begin
        timeout("out_valid_dropped");
        seen = 1'b0;
      end
    end
  end

  initial begin
    logic [127:0] old, a;
    logic [1:0]   s;
    logic [63:0]  r;
    int           k;

    #12;
    chk_i("reset_in_ready", int'(in_ready), 1);
    chk_i("reset_out_valid", int'(out_valid), 0);
    chk_i("reset_illegal", int'(illegal), 0);
    chk_v("reset_vd", vd, '0);
    @(negedge clk);
    rst = 1'b0;

    force_rdy = 1'b1;
    a = {64'hAAAA_BBBB_CCCC_DDDD, 64'h1234_5678_9ABC_DEF0};
    issue(2'b11, 1'b0, 1'b0, 4'd2, 3'd0, 64'h4000_0000_0000_0000, a, 128'h1, rand128(),
          1'b1, {64'hAAAA_BBBB_CCCC_DDDD, 64'h4000_0000_0000_0000});
    issue(2'b10, 1'b1, 1'b1, 4'd3, 3'd0, 64'hFFFF_FFFF_3F80_0000, rand128(), rand128(), rand128(),
          1'b1, {32'hFFFF_FFFF, {3{32'h3F80_0000}}});
    issue(2'b10, 1'b1, 1'b0, 4'd4, 3'd0, 64'h0000_0000_3F80_0000, rand128(), rand128(), rand128(),
          1'b1, {4{32'h7FC0_0000}});
    old = 128'h0707_0606_0505_0404_0303_0202_0101_0000;
    issue(2'b01, 1'b1, 1'b0, 4'd6, 3'd2, 64'hFFFF_FFFF_FFFF_3C00, rand128(), rand128(), old,
          1'b1, {16'h0707, 16'h0606, {4{16'h3C00}}, 16'h0101, 16'h0000});
    old = rand128();
    issue(2'b00, 1'b1, 1'b1, 4'd8, 3'd0, {$urandom, $urandom}, rand128(), rand128(), old, 1'b1, old);
    old = rand128();
    issue(2'b01, 1'b1, 1'b1, 4'd0, 3'd0, 64'hFFFF_FFFF_FFFF_3C00, rand128(), rand128(), old, 1'b1, old);
    old = rand128();
    issue(2'b10, 1'b0, 1'b1, 4'd2, 3'd3, {$urandom, $urandom}, rand128(), rand128(), old, 1'b1, old);
    drain(50);

    // Consumer stalls for five cycles: output must hold still.
    hold_rdy = 1'b1;
    issue(2'b11, 1'b1, 1'b0, 4'd1, 3'd0, 64'h3FF0_0000_0000_0000, rand128(), rand128(), rand128(),
          1'b0, '0);
    k = 0;
    while (!out_valid && k < 20) begin
      @(negedge clk);
      k++;
    end
    if (!out_valid) timeout("stall_out_valid");
    repeat (5) @(negedge clk);
    chk_i("stall_in_ready", int'(in_ready), 0);
    chk_i("stall_out_valid", int'(out_valid), 1);
    hold_rdy = 1'b0;
    drain(20);

    // Reset in the middle of a busy operation aborts it immediately.
    issue(2'b10, 1'b1, 1'b0, 4'd4, 3'd0, 64'hFFFF_FFFF_4000_0000, rand128(), rand128(), rand128(),
          1'b0, '0);
    @(posedge clk);
    #2;
    rst = 1'b1;
    #1;
    chk_i("midbusy_rst_out_valid", int'(out_valid), 0);
    chk_i("midbusy_rst_in_ready", int'(in_ready), 1);
    chk_i("midbusy_rst_illegal", int'(illegal), 0);
    chk_v("midbusy_rst_vd", vd, '0);
    q.delete();
    @(negedge clk);
    rst = 1'b0;

    force_rdy = 1'b0;
    for (int n = 0; n < 150; n++) begin
      k = $urandom_range(0, 9);
      s = (k == 0) ? 2'b00 : 2'((k % 3) + 1);
      r = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) begin
        if (s == 2'b01) r[63:16] = '1;
        else if (s == 2'b10) r[63:32] = '1;
      end
      issue(s, 1'($urandom), 1'($urandom), 4'($urandom_range(0, 15)), 3'($urandom_range(0, 7)),
            r, rand128(), rand128(), rand128(), 1'b0, '0);
    end
    drain(200);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
